// File: rtl/oled_text_scheduler.sv
// oled_text_scheduler: init list, 32-cell shadow buffer and
// dirty-cell streaming onto the 9-bit OLED driver command port.
module oled_text_scheduler #(
  parameter int unsigned COLS      = 16,
  parameter logic [6:0]  ROW1_BASE = 7'h40,
  parameter bit          INIT_WAIT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       refresh_all,
  output logic       init_done,
  output logic       idle,
  input  logic       oled_ready,
  output logic [8:0] oled_cmd,
  output logic       oled_strobe,
  output logic       oled_wait
);

  typedef enum logic [1:0] {
    S_INIT,
    S_SCAN,
    S_ADDR,
    S_DATA
  } state_t;

  localparam logic [3:0] LAST_COL = 4'(COLS - 1);

  state_t      r_state;
  logic [2:0]  r_init_idx;
  logic [7:0]  r_buf [32];
  logic [31:0] r_dirty;
  logic [6:0]  r_cur;
  logic        r_cur_vld;
  logic [4:0]  r_ptr;
  logic        r_strobe;
  logic [8:0]  r_cmd;
  logic        r_wait;
  logic        r_init_done;

  logic        w_issue;
  logic [6:0]  w_addr7;
  logic [8:0]  w_init_cmd;
  logic        w_data_issue;
  logic [31:0] w_dirty_nxt;

  // A new command may only follow a cycle with strobe low.
  assign w_issue = oled_ready & ~r_strobe;

  assign w_addr7 = (r_ptr[4] ? ROW1_BASE : 7'h00)
                 + {3'b000, r_ptr[3:0]};

  assign w_data_issue = (r_state == S_DATA) & w_issue;

  always_comb begin
    w_init_cmd = 9'h017;
    unique case (r_init_idx)
      3'd0:    w_init_cmd = 9'h038;
      3'd1:    w_init_cmd = 9'h00C;
      3'd2:    w_init_cmd = 9'h001;
      3'd3:    w_init_cmd = 9'h006;
      default: w_init_cmd = 9'h017;
    endcase
  end

  // Host set is applied after the send clear so a colliding write wins.
  always_comb begin
    w_dirty_nxt = r_dirty;
    if (w_data_issue)
      w_dirty_nxt[r_ptr] = 1'b0;
    if (refresh_all)
      w_dirty_nxt = '1;
    if (wr_en)
      w_dirty_nxt[wr_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_INIT;
      r_init_idx  <= 3'd0;
      for (int i = 0; i < 32; i++)
        r_buf[i] <= 8'h20;
      r_dirty     <= '0;
      r_cur       <= 7'h00;
      r_cur_vld   <= 1'b0;
      r_ptr       <= 5'd0;
      r_strobe    <= 1'b0;
      r_cmd       <= 9'h000;
      r_wait      <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_dirty  <= w_dirty_nxt;
      if (wr_en)
        r_buf[wr_addr] <= wr_data;

      unique case (r_state)
        S_INIT: begin
          if (w_issue) begin
            r_strobe <= 1'b1;
            r_cmd    <= w_init_cmd;
            r_wait   <= INIT_WAIT;
            if (r_init_idx == 3'd4) begin
              r_init_done <= 1'b1;
              r_cur_vld   <= 1'b0;
              r_state     <= S_SCAN;
            end else begin
              r_init_idx <= r_init_idx + 3'd1;
            end
          end
        end
        S_SCAN: begin
          if (r_dirty[r_ptr]) begin
            if (r_cur_vld && (r_cur == w_addr7))
              r_state <= S_DATA;
            else
              r_state <= S_ADDR;
          end else begin
            r_ptr <= r_ptr + 5'd1;
          end
        end
        S_ADDR: begin
          if (w_issue) begin
            r_strobe <= 1'b1;
            r_cmd    <= {2'b01, w_addr7};
            r_wait   <= INIT_WAIT;
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_issue) begin
            r_strobe  <= 1'b1;
            r_cmd     <= {1'b1, r_buf[r_ptr]};
            r_wait    <= INIT_WAIT;
            r_cur     <= w_addr7 + 7'd1;
            r_cur_vld <= (r_ptr[3:0] != LAST_COL);
            r_ptr     <= r_ptr + 5'd1;
            r_state   <= S_SCAN;
          end
        end
        default: r_state <= S_INIT;
      endcase

      if (refresh_all)
        r_cur_vld <= 1'b0;
    end
  end

  assign idle = r_init_done & ~|r_dirty
              & (r_state == S_SCAN)
              & oled_ready & ~r_strobe;

  assign init_done   = r_init_done;
  assign oled_cmd    = r_cmd;
  assign oled_strobe = r_strobe;
  assign oled_wait   = r_wait;

endmodule

// File: doc/oled_text_scheduler.md
Name: oled_text_scheduler

Overview:
Sequences the 9-bit OLED command interface (command/strobe/ready/wait_for_busy) for a 16x2 character display in text mode. Runs the power-up init command list, then holds a 32-cell character shadow buffer written by a host. It streams only changed ("dirty") cells to the display and skips DDRAM address commands when the display cursor is already positioned. It sits between host logic and the existing oled driver module.

Parameters:
COLS, 16, characters per row (fixed 16; scan pointer is 5 bits)
ROW1_BASE, 7'h40, DDRAM address of row 1 column 0
INIT_WAIT, 1, value driven on oled_wait for every command issued (1 = driver polls busy)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
wr_en  input  1  host write strobe, one cell per cycle, always accepted
wr_addr  input  5  cell index: [4]=row, [3:0]=column
wr_data  input  8  character code
refresh_all  input  1  pulse: mark all 32 cells dirty, invalidate cursor
init_done  output  1  high once init list completed
idle  output  1  init_done and no dirty cells and no command pending
oled_ready  input  1  driver ready (from oled.ready)
oled_cmd  output  9  {rs, data[7:0]} to driver
oled_strobe  output  1  one-cycle command strobe
oled_wait  output  1  wait_for_busy to driver

Behaviour:
- Reset (reset=0, async): oled_strobe=0, oled_cmd=9'h000, oled_wait=0, init_done=0, idle=0; buffer cells=8'h20; dirty=0; cursor_valid=0; scan_ptr=0; state=INIT, init_idx=0. Reset mid-command drops strobe at once; init restarts after release.
- Issue rule: oled_strobe asserted for exactly one cycle, only when oled_ready=1 and oled_strobe was 0 on the previous cycle. oled_cmd/oled_wait are set in the strobe cycle and held until the next strobe.
- INIT: issues, in order, 9'h038 (function set, 8-bit, 2 lines), 9'h00C (display on), 9'h001 (clear), 9'h006 (entry increment), 9'h017 (character mode, power on). After the 5th strobe: init_done=1, cursor_valid=0, state=SCAN.
- SCAN: one cell examined per cycle at scan_ptr. If dirty: if cursor_valid and cursor==cell address go to DATA, else go to ADDR. If not dirty: scan_ptr+1, wrapping 31->0. A dirty cell is reached in at most 32 cycles.
- ADDR: on issue, oled_cmd={1'b0,1'b1,addr7}, where addr7 = (row ? ROW1_BASE : 0) + column. Then DATA.
- DATA: on issue, oled_cmd={1'b1,buffer[cell]}, using the character captured in the strobe cycle. Clear dirty[cell] in the same cycle. Set cursor=addr7+1 and cursor_valid=1, except column 15, where cursor_valid=0. scan_ptr=cell+1 (wrap). Return to SCAN.
- Host write: buffer[wr_addr]<=wr_data and dirty[wr_addr]<=1 every cycle wr_en=1, including during INIT.
  - A write colliding with the dirty clear on the same cell in the same cycle: the set wins; the cell is re-sent later with the new value.
  - A write to a cell between its ADDR and DATA issue: DATA sends the newest value.
- refresh_all: sets all dirty bits and cursor_valid=0. Same-cycle wr_en is also applied.
- idle = init_done and dirty==0 and state==SCAN and oled_ready and !oled_strobe; combinational from registers.
- oled_wait = INIT_WAIT for all commands.

Test Plan:
- Release reset with the driver model ready -> exactly 5 strobes with cmds 038, 00C, 001, 006, 017, each only after ready re-asserts; then init_done=1 and idle=1.
- After init, write addr 5 = 'A' -> cmds 085 then 141; dirty clears; idle returns to 1.
- Write addrs 2,3,4 = "xyz" back-to-back -> 082, 178, 179, 17A (address issued once only).
- Write addr 15='p', addr 16='q' -> 08F, 170, C0, 171 (cursor invalidated at column 15, row-1 address issued).
- wr_en to cell 7 in the exact cycle its DATA strobe issues old 'a' (new 'b') -> 'a' sent, then 087, 162 sent later. With oled_ready held low for 50 cycles -> no strobe during that time.
- Assert reset during the ADDR phase of a refresh -> strobe=0 immediately, all outputs at reset values; after release the full init list replays before any data command.
